clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
// - NUM_CH independent clock-enable/tick generators driven from the 50 MHz board clock.
// - Each channel counts to a divisor that can be reloaded at runtime. Reloads are glitch-free.
// - Each channel provides two outputs: a 1-cycle tick (for counter/display logic) and a 50 % toggle output.
// - Replaces the fixed 1 s toggle divider. Feeds the 0-9999 counter (1 Hz), display scan (~1 kHz) and debounce.
// PARAMETERS
// - NUM_CH    4           number of divider channels
// - DIV_W     32          divisor/counter width; max divisor 2^DIV_W-1
// - DEF_DIV   50_000_000  reset divisor for every channel (1 Hz tick at 50 MHz)
// - CH_W      2           width of ld_ch; CH_W >= clog2(NUM_CH), minimum 1
// PORTS
// - clk      in   1       system clock, 50 MHz, all logic on posedge
// - rst_n    in   1       synchronous reset, active-low
// - en       in   NUM_CH  per-channel count enable
// - clr      in   NUM_CH  per-channel synchronous clear strobe
// - ld       in   1       divisor load strobe, 1 cycle
// - ld_ch    in   CH_W    channel addressed by ld
// - ld_div   in   DIV_W   new divisor value
// - tick     out  NUM_CH  1-cycle pulse, one per divisor period
// - clk_out  out  NUM_CH  toggles on every tick; period = 2*divisor
// - pend     out  NUM_CH  shadow divisor loaded, not yet active
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - cnt=0; active div=DEF_DIV; shadow=DEF_DIV.
//   - tick=0, clk_out=0, pend=0 on all channels.
// - Effective divisor: d = (div<=1) ? 1 : div. Writing 0 or 1 means "tick every cycle".
// - Counting, when en[i]=1 and clr[i]=0:
//   - If cnt==d-1: cnt<=0, tick[i]<=1, clk_out[i]<=~clk_out[i]. Otherwise cnt<=cnt+1 and tick[i]<=0.
//   - Ticks are exactly d cycles apart. The first tick after reset/clr comes d cycles after counting starts.
// - en[i]=0: cnt and clk_out hold, tick[i]<=0. Re-enabling resumes from the held count.
// - clr[i]=1: cnt<=0, tick[i]<=0, clk_out[i]<=0. Active divisor and shadow are kept.
//   - clr has priority over en and over a terminal count in the same cycle.
// - Load (ld=1, ld_ch<NUM_CH): shadow[ld_ch]<=ld_div, pend[ld_ch]<=1.
//   - ld_ch>=NUM_CH: load ignored, no state change.
//   - A second load before apply overwrites the shadow (last write wins).
// - Apply: shadow->active and pend<=0 happens at the first of:
//   - (a) the terminal-count cycle, so the next period already uses the new d;
//   - (b) a clr[i] cycle;
//   - (c) any cycle where en[i]=0.
// - A load and an apply event in the same cycle: the new ld_div is applied directly and pend stays 0.
// - No partial-period glitch: a period in progress always completes with the old divisor.
// - tick and clk_out are registered outputs; there is no combinational path from inputs to outputs.
// - Counter width: cnt is DIV_W bits and compares against d-1. It cannot overflow because d <= 2^DIV_W-1.
// - Reset mid-period or mid-pending: all state returns to the reset values and the pending load is lost.
// STRUCTURE
// - Package clk_div_pkg: DEF_DIV, the 50 MHz CLK_HZ constant, and divisor constants
//   DIV_1HZ=50_000_000, DIV_1KHZ=50_000, DIV_100HZ=500_000.
// - Sub-module clk_div_ch: one channel holding cnt, active/shadow divisor, pend, tick and clk_out.
//   - Inputs: en, clr, ld_hit, ld_div.
// - Top level clk_div_bank: decodes ld_ch to per-channel ld_hit and instantiates NUM_CH copies of clk_div_ch via generate.
// TESTING
// 1. Reset values: rst_n=0 for 3 cycles, then 1 with en=0 -> tick=0, clk_out=0, pend=0, no tick for 100 cycles.
// 2. Period accuracy: DEF_DIV=10, en[0]=1 -> tick[0] every 10 cycles;
//    clk_out[0] 10 cycles high / 10 low; 5 ticks in 50 cycles.
// 3. Glitch-free reload: ch0 d=10; load 4 at cnt=3 -> pend=1;
//    next tick stays 10 cycles after the previous one, then ticks every 4; pend drops at the apply cycle.
// 4. Degenerate divisors and bad address: load 0 -> tick every cycle, clk_out toggles every cycle;
//    ld_ch=3 with NUM_CH=3 -> no channel changes.
// 5. Enable/clear interaction: en low at cnt=6 for 20 cycles -> no tick, cnt holds, resumes 4 cycles later;
//    clr with terminal count -> no tick, cnt=0.
// 6. Reset during pend: load 7, then assert rst_n=0 -> after release d=DEF_DIV, pend=0, clk_out=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-enable divider bank: board clock rate,
// reset divisor and the standard divisors used by the counter, display
// scan and debounce consumers.
package clk_div_pkg;

  localparam int unsigned CLK_HZ    = 32'd50_000_000;
  localparam int unsigned DIV_1HZ   = 32'd50_000_000;
  localparam int unsigned DIV_1KHZ  = 32'd50_000;
  localparam int unsigned DIV_100HZ = 32'd500_000;
  localparam int unsigned DEF_DIV   = DIV_1HZ;

endpackage : clk_div_pkg

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active and shadow divisor, pending
// flag, and the registered tick / 50 % toggle outputs. A newly loaded
// divisor waits in the shadow register until a period boundary, clear or
// idle cycle, so a period in progress always finishes with the old value.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ld_hit,
  input  logic [DIV_W-1:0] ld_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  localparam logic [DIV_W-1:0] DEF_DIV_W = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ZERO      = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE       = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] shadow_r;
  logic             pend_r;
  logic             tick_r;
  logic             clk_out_r;

  logic [DIV_W-1:0] last_s;
  logic             term_s;
  logic             apply_s;

  // Terminal count and divisor hand-over decode; divisors 0 and 1 both mean
  // a period of one cycle. The count compares with >= so that a smaller
  // divisor applied while the channel was idle ends the held period at once
  // instead of letting the counter run around its full range.
  always_comb begin
    last_s  = ZERO;
    term_s  = 1'b0;
    apply_s = 1'b0;
    if (div_r > ONE) begin
      last_s = div_r - ONE;
    end else begin
      last_s = ZERO;
    end
    term_s  = en && !clr && (cnt_r >= last_s);
    apply_s = term_s || clr || !en;
  end

  // Period counter with tick pulse and toggle output; clear wins over all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= ZERO;
      tick_r    <= 1'b0;
      clk_out_r <= 1'b0;
    end else if (clr) begin
      cnt_r     <= ZERO;
      tick_r    <= 1'b0;
      clk_out_r <= 1'b0;
    end else if (en) begin
      if (term_s) begin
        cnt_r     <= ZERO;
        tick_r    <= 1'b1;
        clk_out_r <= ~clk_out_r;
      end else begin
        cnt_r     <= cnt_r + ONE;
        tick_r    <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  // Shadow capture and glitch-free hand-over to the active divisor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r    <= DEF_DIV_W;
      shadow_r <= DEF_DIV_W;
      pend_r   <= 1'b0;
    end else if (ld_hit && apply_s) begin
      div_r    <= ld_div;
      shadow_r <= ld_div;
      pend_r   <= 1'b0;
    end else if (ld_hit) begin
      shadow_r <= ld_div;
      pend_r   <= 1'b1;
    end else if (apply_s) begin
      div_r    <= shadow_r;
      pend_r   <= 1'b0;
    end
  end

  assign tick    = tick_r;
  assign clk_out = clk_out_r;
  assign pend    = pend_r;

endmodule : clk_div_ch

// File: rtl/clk_div_bank.sv
// Bank of independent clock-enable/tick generators. Decodes the divisor
// load address into one hit strobe per channel; addresses beyond the last
// channel match nothing and are dropped.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV,
  parameter int unsigned CH_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] clr,
  input  logic              ld,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [DIV_W-1:0]  ld_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] ld_hit_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ld_hit_s[g] = ld && (ld_ch == CH_W'(g));

    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .clr     (clr[g]),
      .ld_hit  (ld_hit_s[g]),
      .ld_div  (ld_div),
      .tick    (tick[g]),
      .clk_out (clk_out[g]),
      .pend    (pend[g])
    );
  end

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: reset, period accuracy, deferred
// reload, degenerate divisors, bad address, enable/clear interaction,
// reset during a pending load, then randomized traffic against a model.
module tb_clk_div_bank;

  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 10;
  localparam int CH_W    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clr;
  logic              ld;
  logic [CH_W-1:0]   ld_ch;
  logic [DIV_W-1:0]  ld_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] pend;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles elapsed in the current period, divisors, flags.
  int                m_cnt [NUM_CH];
  int                m_div [NUM_CH];
  int                m_sh  [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_pend;

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] clr;
    logic              ld;
    logic [CH_W-1:0]   ld_ch;
    logic [DIV_W-1:0]  ld_div;
    logic [NUM_CH-1:0] e_tick;
    logic [NUM_CH-1:0] e_clk;
    logic [NUM_CH-1:0] e_pend;
  } vec_t;

  vec_t tbl [14];

  always #10 clk = ~clk;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV),
    .CH_W    (CH_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .ld      (ld),
    .ld_ch   (ld_ch),
    .ld_div  (ld_div),
    .tick    (tick),
    .clk_out (clk_out),
    .pend    (pend)
  );

  // Advance the model by one clock edge using the inputs held across it.
  function automatic void model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      int d;
      bit boundary;
      bit hit;
      if (!rst_n) begin
        m_cnt[i] = 0; m_div[i] = DEF_DIV; m_sh[i] = DEF_DIV;
        m_pend[i] = 1'b0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
      end else begin
        d        = (m_div[i] <= 1) ? 1 : m_div[i];
        hit      = ld && (int'(ld_ch) == i);
        boundary = 1'b0;
        if (clr[i]) begin
          m_cnt[i] = 0; m_tick[i] = 1'b0; m_clk[i] = 1'b0; boundary = 1'b1;
        end else if (en[i]) begin
          if (m_cnt[i] + 1 >= d) begin
            m_cnt[i] = 0; m_tick[i] = 1'b1; m_clk[i] = ~m_clk[i]; boundary = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 1'b0;
          end
        end else begin
          m_tick[i] = 1'b0; boundary = 1'b1;
        end
        if (hit) begin
          m_sh[i] = int'(ld_div);
          if (boundary) begin
            m_div[i] = int'(ld_div); m_pend[i] = 1'b0;
          end else begin
            m_pend[i] = 1'b1;
          end
        end else if (boundary && m_pend[i]) begin
          m_div[i] = m_sh[i]; m_pend[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic check_vec(input string name, input logic [NUM_CH-1:0] act,
                           input logic [NUM_CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample #1 after the edge and compare against the model.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_vec("model_tick", tick, m_tick);
    check_vec("model_clk_out", clk_out, m_clk);
    check_vec("model_pend", pend, m_pend);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = '0; clr = '0; ld = 1'b0; ld_ch = '0; ld_div = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Step until tick[ch]; n is the number of edges taken.
  task automatic run_to_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < limit);
    if (!tick[ch]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_tick ch%0d: no tick within %0d cycles", ch, limit);
    end
  endtask

  initial begin
    int ntk;
    int prev;
    int hi;
    int n;

    // en, clr, ld, ld_ch, ld_div, exp tick, exp clk_out, exp pend
    tbl[0]  = '{3'b000, 3'b000, 1'b1, 2'd1, 16'd0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b010, 3'b000, 1'b0, 2'd0, 16'd0, 3'b010, 3'b010, 3'b000};
    tbl[2]  = '{3'b010, 3'b000, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
    tbl[3]  = '{3'b010, 3'b000, 1'b1, 2'd3, 16'd5, 3'b010, 3'b010, 3'b000};
    tbl[4]  = '{3'b010, 3'b000, 1'b1, 2'd2, 16'd1, 3'b010, 3'b000, 3'b000};
    tbl[5]  = '{3'b110, 3'b000, 1'b0, 2'd0, 16'd0, 3'b110, 3'b110, 3'b000};
    tbl[6]  = '{3'b110, 3'b100, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
    tbl[7]  = '{3'b111, 3'b000, 1'b1, 2'd2, 16'd3, 3'b110, 3'b110, 3'b000};
    tbl[8]  = '{3'b111, 3'b000, 1'b1, 2'd0, 16'd2, 3'b010, 3'b100, 3'b001};
    tbl[9]  = '{3'b111, 3'b000, 1'b0, 2'd0, 16'd0, 3'b010, 3'b110, 3'b001};
    tbl[10] = '{3'b111, 3'b000, 1'b0, 2'd0, 16'd0, 3'b110, 3'b000, 3'b001};
    tbl[11] = '{3'b111, 3'b001, 1'b0, 2'd0, 16'd0, 3'b010, 3'b010, 3'b000};
    tbl[12] = '{3'b111, 3'b000, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
    tbl[13] = '{3'b111, 3'b000, 1'b0, 2'd0, 16'd0, 3'b111, 3'b111, 3'b111 & 3'b000};

    // Reset values and 100 idle cycles without a tick.
    do_reset();
    check_vec("rst_tick", tick, 3'b000);
    check_vec("rst_clk_out", clk_out, 3'b000);
    check_vec("rst_pend", pend, 3'b000);
    ntk = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tick != 3'b000) ntk++;
    end
    check_int("idle_ticks", ntk, 0);

    // Period accuracy with the default divisor of 10.
    en = 3'b001; prev = 0; ntk = 0; hi = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (tick[0]) begin
        ntk++;
        if (prev == 0) check_int("first_tick_edge", k, 10);
        else           check_int("tick_gap", k - prev, 10);
        prev = k;
      end
      if (k >= 21 && k <= 40 && clk_out[0]) hi++;
    end
    check_int("ticks_in_50", ntk, 5);
    check_int("clk_out_high_len", hi, 10);

    // Reload 4 mid-period (count 3): old period completes, then period 4.
    repeat (3) step();
    ld = 1'b1; ld_ch = 2'd0; ld_div = 16'd4;
    step();
    ld = 1'b0;
    check_vec("reload_pend_set", pend, 3'b001);
    run_to_tick(0, 20, n);
    check_int("reload_old_period", n, 6);
    check_vec("reload_pend_clear", pend, 3'b000);
    run_to_tick(0, 20, n);
    check_int("reload_new_period_a", n, 4);
    run_to_tick(0, 20, n);
    check_int("reload_new_period_b", n, 4);

    // Degenerate divisors, bad address, same-cycle load/apply (table).
    do_reset();
    for (int r = 0; r < 14; r++) begin
      en = tbl[r].en; clr = tbl[r].clr; ld = tbl[r].ld;
      ld_ch = tbl[r].ld_ch; ld_div = tbl[r].ld_div;
      step();
      check_vec($sformatf("tbl%0d_tick", r), tick, tbl[r].e_tick);
      check_vec($sformatf("tbl%0d_clk_out", r), clk_out, tbl[r].e_clk);
      check_vec($sformatf("tbl%0d_pend", r), pend, tbl[r].e_pend);
    end

    // Enable low at count 6 for 20 cycles, then resume.
    do_reset();
    en = 3'b001;
    repeat (6) step();
    en = 3'b000; ntk = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick[0]) ntk++;
    end
    check_int("hold_ticks", ntk, 0);
    en = 3'b001;
    run_to_tick(0, 20, n);
    check_int("resume_gap", n, 4);
    // Clear on the terminal-count cycle suppresses the tick.
    repeat (9) step();
    clr = 3'b001;
    step();
    clr = 3'b000;
    check_vec("clr_term_tick", tick & 3'b001, 3'b000);
    check_vec("clr_term_clk_out", clk_out & 3'b001, 3'b000);
    run_to_tick(0, 20, n);
    check_int("after_clr_period", n, 10);

    // Reset while a load is pending discards it.
    do_reset();
    en = 3'b001;
    repeat (3) step();
    ld = 1'b1; ld_ch = 2'd0; ld_div = 16'd7;
    step();
    ld = 1'b0;
    check_vec("pend_before_rst", pend, 3'b001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_vec("pend_after_rst", pend, 3'b000);
    check_vec("clk_out_after_rst", clk_out, 3'b000);
    run_to_tick(0, 30, n);
    check_int("period_after_rst", n, 10);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NUM_CH; i++) begin
        en[i]  = ($urandom_range(0, 9) < 8);
        clr[i] = ($urandom_range(0, 49) == 0);
      end
      ld     = ($urandom_range(0, 4) == 0);
      ld_ch  = CH_W'($urandom_range(0, 3));
      ld_div = DIV_W'($urandom_range(0, 12));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_clk_div_bank
